// File: rtl/irq_controller_n.sv
// irq_controller_n: N_SRC-source interrupt controller with CPU handshake and register window; define IRQ_EDGE_EN for edge-mode sources
module irq_controller_n #(
    parameter int N_SRC = 8,
    parameter int TIMER_ID = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       a,
    input  logic [31:0]      d,
    input  logic             we,
    output logic [31:0]      spo,
    input  logic [N_SRC-1:0] irq_src,
    output logic             interrupt,
    output logic             int_istimer,
    input  logic             int_reply
);
    typedef enum logic [1:0] {IDLE, ASSERT, INSERVICE} state_t;
    state_t state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d, enable_q, enable_d, eligible;
    logic [4:0] cur_id_q, cur_id_d, win_id;
    logic [31:0] rd_pend, rd_en, rd_edge, claim;
    logic complete, unused_d;
    assign unused_d = ^d;
    assign eligible = pending_q & enable_q;
    assign complete = we && a == 3'd3 && state_q == INSERVICE && d[4:0] == cur_id_q;
    assign enable_d = (we && a == 3'd1) ? d[N_SRC-1:0] : enable_q;
    assign interrupt = state_q == ASSERT;
    assign int_istimer = interrupt && cur_id_q == 5'(TIMER_ID);
`ifdef IRQ_EDGE_EN
    logic [N_SRC-1:0] src_q, edge_q, edge_d, clr;
    assign edge_d = (we && a == 3'd4) ? d[N_SRC-1:0] : edge_q;
    assign clr = ((we && a == 3'd0) ? d[N_SRC-1:0] : '0) | (complete ? N_SRC'(1) << cur_id_q : '0);
    // previous source sample for rise detection, and the edge/level mask
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
            edge_q <= '0;
        end else begin
            src_q <= irq_src;
            edge_q <= edge_d;
        end
    end
`endif
    // level bits mirror the sampled source; edge bits latch a rise until cleared, set winning over clear
    always_comb begin
        pending_d = irq_src;
`ifdef IRQ_EDGE_EN
        for (int i = 0; i < N_SRC; i++)
            if (edge_q[i]) pending_d[i] = (irq_src[i] & ~src_q[i]) | (pending_q[i] & ~clr[i]);
`endif
    end
    // fixed priority: lowest eligible index wins
    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (eligible[i]) win_id = 5'(i);
    end
    // handshake FSM: request held until reply, then service until matching COMPLETE
    always_comb begin
        state_d = state_q;
        cur_id_d = cur_id_q;
        unique case (state_q)
            IDLE: if (|eligible) begin
                state_d = ASSERT;
                cur_id_d = win_id;
            end
            ASSERT: state_d = int_reply ? INSERVICE : ASSERT;
            INSERVICE: state_d = complete ? IDLE : INSERVICE;
            default: state_d = IDLE;
        endcase
    end
    // register read mux, zero-extended to the bus width
    always_comb begin
        rd_pend = '0;
        rd_pend[N_SRC-1:0] = pending_q;
        rd_en = '0;
        rd_en[N_SRC-1:0] = enable_q;
        rd_edge = '0;
`ifdef IRQ_EDGE_EN
        rd_edge[N_SRC-1:0] = edge_q;
`endif
        claim = (state_q == IDLE) ? {|eligible, 26'b0, win_id} : {1'b1, 26'b0, cur_id_q};
        spo = (a == 3'd0) ? rd_pend : (a == 3'd1) ? rd_en : (a == 3'd2) ? claim : (a == 3'd4) ? rd_edge : '0;
    end
    // state, pending, enable and claimed id registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_id_q <= '0;
            pending_q <= '0;
            enable_q <= '0;
        end else begin
            state_q <= state_d;
            cur_id_q <= cur_id_d;
            pending_q <= pending_d;
            enable_q <= enable_d;
        end
    end
endmodule

// File: tb/tb_irq_controller_n.sv
// tb_irq_controller_n: vector table, corner sequences and random run against a behavioural model
module tb_irq_controller_n;
    logic clk = 0, rst = 1, we = 0, int_reply = 0, interrupt, int_istimer;
    logic [2:0] a = 0;
    logic [31:0] d = 0, spo;
    logic [7:0] irq_src = 0;
    logic we3 = 0, interrupt3, int_istimer3;
    logic [2:0] a3 = 0;
    logic [31:0] d3 = 0, spo3;
    logic [2:0] irq_src3 = 0;
    int total = 0, bad = 0;
    always #5 clk = ~clk;

    irq_controller_n #(.N_SRC(8), .TIMER_ID(0)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq_src(irq_src),
        .interrupt(interrupt), .int_istimer(int_istimer), .int_reply(int_reply));
    irq_controller_n #(.N_SRC(3), .TIMER_ID(1)) dut3 (
        .clk(clk), .rst(rst), .a(a3), .d(d3), .we(we3), .spo(spo3), .irq_src(irq_src3),
        .interrupt(interrupt3), .int_istimer(int_istimer3), .int_reply(1'b0));

    typedef struct {
        logic [2:0] a; logic we; logic [31:0] d; logic [7:0] src; logic rep;
        logic xi; logic xt; logic [31:0] xs;
    } vec_t;
    vec_t tv[27];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] aa, input logic w, input logic [31:0] dd, input logic [7:0] s, input logic r);
        a = aa; we = w; d = dd; irq_src = s; int_reply = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // behavioural model: per-source bit arrays plus a phase number (0 idle, 1 requesting, 2 in service)
    bit m_pend[8], m_en[8];
    int m_phase, m_cur;

    function automatic int m_lowest();
        for (int i = 0; i < 8; i++) if (m_pend[i] && m_en[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] aa);
        logic [31:0] r = 0;
        int w;
        if (aa == 0) for (int i = 0; i < 8; i++) r[i] = m_pend[i];
        if (aa == 1) for (int i = 0; i < 8; i++) r[i] = m_en[i];
        if (aa == 2) begin
            w = m_lowest();
            if (m_phase != 0) r = 32'h8000_0000 + m_cur;
            else if (w >= 0) r = 32'h8000_0000 + w;
        end
        return r;
    endfunction

    initial begin
        tv[0]  = '{1, 1, 5, 8'h00, 0, 0, 0, 32'h5};
        tv[1]  = '{2, 0, 0, 8'h04, 0, 0, 0, 32'h8000_0002};
        tv[2]  = '{2, 0, 0, 8'h04, 0, 1, 0, 32'h8000_0002};
        tv[3]  = '{0, 0, 0, 8'h04, 1, 0, 0, 32'h4};
        tv[4]  = '{3, 1, 2, 8'h04, 0, 0, 0, 32'h0};
        tv[5]  = '{2, 0, 0, 8'h04, 0, 1, 0, 32'h8000_0002};
        tv[6]  = '{2, 0, 0, 8'h04, 1, 0, 0, 32'h8000_0002};
        tv[7]  = '{3, 1, 2, 8'h00, 0, 0, 0, 32'h0};
        tv[8]  = '{2, 0, 0, 8'h00, 0, 0, 0, 32'h0};
        tv[9]  = '{1, 1, 32'hFF, 8'h21, 0, 0, 0, 32'hFF};
        tv[10] = '{2, 0, 0, 8'h21, 0, 1, 1, 32'h8000_0000};
        tv[11] = '{0, 0, 0, 8'h21, 1, 0, 0, 32'h21};
        tv[12] = '{3, 1, 0, 8'h20, 0, 0, 0, 32'h0};
        tv[13] = '{2, 0, 0, 8'h20, 0, 1, 0, 32'h8000_0005};
        tv[14] = '{2, 0, 0, 8'h20, 1, 0, 0, 32'h8000_0005};
        tv[15] = '{3, 1, 5, 8'h10, 0, 0, 0, 32'h0};
        tv[16] = '{2, 0, 0, 8'h10, 0, 1, 0, 32'h8000_0004};
        tv[17] = '{2, 0, 0, 8'h10, 1, 0, 0, 32'h8000_0004};
        tv[18] = '{3, 1, 1, 8'h00, 0, 0, 0, 32'h0};
        tv[19] = '{3, 1, 31, 8'h00, 0, 0, 0, 32'h0};
        tv[20] = '{2, 0, 0, 8'h00, 0, 0, 0, 32'h8000_0004};
        tv[21] = '{3, 1, 4, 8'h00, 0, 0, 0, 32'h0};
        tv[22] = '{2, 0, 0, 8'h00, 0, 0, 0, 32'h0};
        tv[23] = '{6, 1, 32'hFFFF_FFFF, 8'h00, 0, 0, 0, 32'h0};
        tv[24] = '{1, 0, 0, 8'h00, 0, 0, 0, 32'hFF};
        tv[25] = '{1, 1, 32'hFFFF_FFFF, 8'h00, 0, 0, 0, 32'hFF};
        tv[26] = '{4, 1, 0, 8'h00, 0, 0, 0, 32'h0};
        drive(0, 0, 0, 0, 0);
        tick;
        tick;
        rst = 0;
        a = 1;
        #1;
        check("reset_enable", spo, 0);
        a = 2;
        #1;
        check("reset_claim", spo, 0);
        check("reset_interrupt", interrupt, 0);
        for (int i = 0; i < 27; i++) begin
            drive(tv[i].a, tv[i].we, tv[i].d, tv[i].src, tv[i].rep);
            tick;
            check($sformatf("vec%0d_interrupt", i), interrupt, tv[i].xi);
            check($sformatf("vec%0d_istimer", i), int_istimer, tv[i].xt);
            check($sformatf("vec%0d_spo", i), spo, tv[i].xs);
        end
        // narrow instance masks ENABLE to its source count
        a3 = 1; d3 = 32'hFFFF_FFFF; we3 = 1;
        tick;
        we3 = 0;
        #1;
        check("n3_enable_mask", spo3, 32'h7);
        // reset asserted while a request is outstanding
        drive(1, 1, 32'hFF, 8'hFF, 0);
        tick;
        drive(2, 0, 0, 8'hFF, 0);
        begin
            int n = 0;
            while (!interrupt && n < 10) begin tick; n++; end
            check("reach_assert", interrupt, 1);
        end
        rst = 1;
        tick;
        check("rst_mid_interrupt", interrupt, 0);
        check("rst_mid_istimer", int_istimer, 0);
        check("rst_mid_claim", spo, 0);
        a = 1;
        #1;
        check("rst_mid_enable", spo, 0);
        rst = 0;
        drive(0, 0, 0, 0, 0);
        tick;
`ifdef IRQ_EDGE_EN
        drive(1, 1, 8, 0, 0);
        tick;
        drive(4, 1, 8, 0, 0);
        tick;
        check("edge_mask", spo, 8);
        drive(0, 0, 0, 8, 0);
        tick;
        drive(0, 0, 0, 0, 0);
        tick;
        check("edge_pend_held", spo, 8);
        check("edge_interrupt", interrupt, 1);
        tick;
        check("edge_pend_held2", spo, 8);
        drive(0, 0, 0, 0, 1);
        tick;
        drive(3, 1, 3, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0);
        #1;
        check("edge_pend_cleared", spo, 0);
        tick;
        tick;
        check("edge_no_reassert", interrupt, 0);
`endif
        // randomized run against the model, level mode only
        rst = 1;
        tick;
        rst = 0;
        foreach (m_pend[i]) begin m_pend[i] = 0; m_en[i] = 0; end
        m_phase = 0;
        m_cur = 0;
        for (int c = 0; c < 2000; c++) begin
            logic [2:0] ra;
            logic rw, rr;
            logic [31:0] rd;
            logic [7:0] rs;
            int w;
            ra = 3'($urandom_range(0, 7));
            if (ra == 4) ra = 1;
            rw = $urandom_range(0, 3) == 0;
            rr = $urandom_range(0, 2) == 0;
            rs = 8'($urandom & $urandom);
            rd = $urandom;
            if (ra == 3) rd = $urandom_range(0, 1) ? 32'(m_cur) : 32'($urandom_range(0, 31));
            drive(ra, rw, rd, rs, rr);
            w = m_lowest();
            if (m_phase == 0 && w >= 0) begin m_phase = 1; m_cur = w; end
            else if (m_phase == 1 && rr) m_phase = 2;
            else if (m_phase == 2 && rw && ra == 3 && rd[4:0] == m_cur) m_phase = 0;
            if (rw && ra == 1) for (int i = 0; i < 8; i++) m_en[i] = rd[i];
            for (int i = 0; i < 8; i++) m_pend[i] = rs[i];
            tick;
            check("rand_interrupt", interrupt, m_phase == 1);
            check("rand_istimer", int_istimer, m_phase == 1 && m_cur == 0);
            check("rand_spo", spo, m_read(ra));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
